axi4_burst_mem_slave: RTL
=========================

// Module: axi4_burst_mem_slave
// PURPOSE
//   AXI4 slave memory: MEMORY_DEPTH words of DATA_WIDTH bits, reached through the axi4_if signal set.
//   Extends the single-mode slave with FIXED/INCR/WRAP bursts, WSTRB byte enables, narrow transfers,
//   per-beat error responses and independent read/write engines.
//   Sits behind axi4_if (DUT side); driven by the TEST clocking block, checked by the ASSERT modport.
// PARAMETERS
//   DATA_WIDTH    32    data bus width; power of 2, 8..1024
//   ADDR_WIDTH    16    byte address width
//   MEMORY_DEPTH  1024  number of DATA_WIDTH words
// PORTS
//   ACLK            in   1             clock, rising edge
//   ARESETn         in   1             reset, asynchronous, active-low
//   AWADDR, ARADDR  in   ADDR_WIDTH    burst start byte address (write / read)
//   AWLEN, ARLEN    in   8             beats minus 1
//   AWSIZE, ARSIZE  in   3             log2 of bytes per beat
//   AWBURST,ARBURST in   2             00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//   AWVALID,ARVALID in   1             address valid
//   AWREADY,ARREADY out  1             address ready
//   WDATA           in   DATA_WIDTH    write data
//   WSTRB           in   DATA_WIDTH/8  byte-lane write enables
//   WLAST, WVALID   in   1             last write beat / write valid
//   WREADY          out  1             write ready
//   BRESP           out  2             write response: 00 OKAY, 10 SLVERR
//   BVALID          out  1             response valid
//   BREADY          in   1             response ready
//   RDATA           out  DATA_WIDTH    read data
//   RRESP           out  2             per-beat read response
//   RLAST, RVALID   out  1             last read beat / read valid
//   RREADY          in   1             read ready
// BEHAVIOUR
//   Reset: every READY, BVALID, RVALID and RLAST = 0; BRESP = RRESP = 0; RDATA = 0. Memory is not cleared.
//     Asserting reset mid-burst returns both FSMs to IDLE and drops the burst: no B, no further R beats.
//   Write FSM W_IDLE -> W_DATA -> W_RESP
//     - W_IDLE: AWREADY=1. On AW handshake, latch addr/len/size/burst; next cycle AWREADY=0, WREADY=1.
//     - W_DATA: each WVALID&WREADY beat writes the enabled lanes; the beat counter ends the burst after len+1 beats.
//       WLAST low on the final beat, or high earlier, sets BRESP=SLVERR. WLAST never terminates the burst.
//     - W_RESP: WREADY=0, BVALID=1. BVALID/BRESP stay stable until BREADY, then W_IDLE.
//     - One outstanding write: AWREADY stays low until the B handshake completes.
//   Read FSM R_IDLE -> R_DATA; runs independently of the write FSM.
//     - R_IDLE: ARREADY=1. On AR handshake, first beat appears the next cycle: RVALID=1, registered read.
//     - R_DATA: while RVALID&!RREADY, RDATA/RRESP/RLAST hold. Next beat presents the cycle after each handshake.
//       RLAST=1 on beat len+1; after its handshake, return to R_IDLE (ARREADY=1).
//   Addressing
//     - Word index = addr >> log2(DATA_WIDTH/8). Narrow beats use lanes addr[lane bits].
//     - FIXED: addr constant. INCR: addr = (addr aligned to size) + (1<<size).
//     - WRAP: boundary = (len+1)<<size; addr wraps to the aligned boundary base.
//   Errors: the whole burst is SLVERR, with no writes and RDATA=0, when any of these holds:
//       size > log2(DATA_WIDTH/8); burst=11; WRAP with len not in {1,3,7,15}.
//     Per beat: word index >= MEMORY_DEPTH -> write suppressed, RDATA=0, RRESP=SLVERR for that beat.
//     BRESP is sticky SLVERR once any beat errs.
//   Same-cycle read and write to the same word: read returns old data (read-before-write).
//   4KB-crossing INCR bursts are not checked.
// TESTING
//   INCR, AWADDR=0x10, len=3, size=2, WSTRB=F, data 1..4; then read back -> RDATA 1,2,3,4; RLAST on beat 4; OKAY.
//   WRAP, ARADDR=0x18, len=3, size=2 -> words read in order 0x18,0x1C,0x10,0x14.
//   WSTRB=0x3, data 0xAABBCCDD over 0xFFFFFFFF -> readback 0xFFFFCCDD.
//   Write to word MEMORY_DEPTH-1 with len=1 -> beat 2 dropped, BRESP=10; no memory corruption.
//   BREADY low 5 cycles / RREADY toggling -> BVALID, RDATA, RLAST held stable; AWREADY low until B handshake.
//   ARESETn pulse mid read burst -> RVALID=0 immediately; after release ARREADY=1, new burst completes OKAY.

Source files
------------

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave: FIXED/INCR/WRAP bursts, byte strobes, narrow beats,
// per-beat SLVERR, independent read and write engines over one word array.
module axi4_burst_mem_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int BPB       = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BPB);
  localparam int IDX_W     = $clog2(MEMORY_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LANE_BITS);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, nxt, wmask;
    step  = ADDR_WIDTH'(1) << size;
    nxt   = (a & ~(step - ADDR_WIDTH'(1))) + step;
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~wmask) | (nxt & wmask);
      default: return nxt;
    endcase
  endfunction

  function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (size > MAX_SIZE) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a >> LANE_BITS} < (ADDR_WIDTH+1)'(MEMORY_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> LANE_BITS);
  endfunction

  // Lanes touched by a beat of 2**size bytes, taken from the size-aligned address.
  function automatic logic [BPB-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] a,
                                               input logic [2:0] size);
    logic [BPB-1:0] m;
    int lo, nb;
    nb = 1 << size;
    lo = int'(a & ADDR_WIDTH'(BPB - 1)) & ~(nb - 1);
    for (int b = 0; b < BPB; b++) m[b] = (b >= lo) && (b < lo + nb);
    return m;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic live;

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) live <= 1'b0;
    else          live <= 1'b1;

  // ---------------- write engine ----------------
  wstate_t               wstate, wstate_nx;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len, w_cnt;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  w_bad_burst, b_err;
  logic                  aw_hs, w_hs, w_final, mem_we;
  logic [BPB-1:0]        mem_be;
  logic [IDX_W-1:0]      w_idx;

  assign AWREADY = live && (wstate == W_IDLE);
  assign WREADY  = (wstate == W_DATA);
  assign BVALID  = (wstate == W_RESP);
  assign BRESP   = b_err ? SLVERR : OKAY;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign w_final = (w_cnt == aw_len);
  assign mem_we  = w_hs && !w_bad_burst && in_range(aw_addr);
  assign mem_be  = WSTRB & lane_mask(aw_addr, aw_size);
  assign w_idx   = widx(aw_addr);

  always_comb begin
    wstate_nx = wstate;
    case (wstate)
      W_IDLE:  if (aw_hs) wstate_nx = W_DATA;
      W_DATA:  if (w_hs && w_final) wstate_nx = W_RESP;
      W_RESP:  if (BREADY) wstate_nx = W_IDLE;
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) wstate <= W_IDLE;
    else          wstate <= wstate_nx;

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      aw_addr <= '0; aw_len <= '0; aw_size <= '0; aw_burst <= '0;
      w_cnt <= '0; w_bad_burst <= 1'b0; b_err <= 1'b0;
    end else if (aw_hs) begin
      aw_addr     <= AWADDR;
      aw_len      <= AWLEN;
      aw_size     <= AWSIZE;
      aw_burst    <= AWBURST;
      w_cnt       <= '0;
      w_bad_burst <= burst_bad(AWLEN, AWSIZE, AWBURST);
      b_err       <= burst_bad(AWLEN, AWSIZE, AWBURST);
    end else if (w_hs) begin
      w_cnt   <= w_cnt + 8'd1;
      aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
      // WLAST is only checked, never used to end the burst.
      if (!in_range(aw_addr) || (WLAST != w_final)) b_err <= 1'b1;
    end

  always_ff @(posedge ACLK)
    if (mem_we)
      for (int b = 0; b < BPB; b++)
        if (mem_be[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];

  // ---------------- read engine ----------------
  rstate_t               rstate, rstate_nx;
  logic [ADDR_WIDTH-1:0] ar_addr, f_addr;
  logic [7:0]            ar_len, r_cnt, f_len;
  logic [2:0]            ar_size, f_size;
  logic [1:0]            ar_burst, f_burst;
  logic                  r_bad_burst, f_bad, f_ok;
  logic                  ar_hs, r_hs, fetch;

  assign ARREADY = live && (rstate == R_IDLE);
  assign RVALID  = (rstate == R_DATA);
  assign ar_hs   = ARVALID && ARREADY;
  assign r_hs    = RVALID && RREADY;
  assign fetch   = ar_hs || (r_hs && !RLAST);

  // The first beat comes straight from the AR channel; later beats from the walked address.
  assign f_addr  = ar_hs ? ARADDR  : ar_addr;
  assign f_len   = ar_hs ? ARLEN   : ar_len;
  assign f_size  = ar_hs ? ARSIZE  : ar_size;
  assign f_burst = ar_hs ? ARBURST : ar_burst;
  assign f_bad   = ar_hs ? burst_bad(ARLEN, ARSIZE, ARBURST) : r_bad_burst;
  assign f_ok    = !f_bad && in_range(f_addr);

  always_comb begin
    rstate_nx = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nx = R_DATA;
      R_DATA:  if (r_hs && RLAST) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) rstate <= R_IDLE;
    else          rstate <= rstate_nx;

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      ar_addr <= '0; ar_len <= '0; ar_size <= '0; ar_burst <= '0;
      r_cnt <= '0; r_bad_burst <= 1'b0;
      RDATA <= '0; RRESP <= OKAY; RLAST <= 1'b0;
    end else if (fetch) begin
      ar_len      <= f_len;
      ar_size     <= f_size;
      ar_burst    <= f_burst;
      r_bad_burst <= f_bad;
      ar_addr     <= next_addr(f_addr, f_len, f_size, f_burst);
      r_cnt       <= ar_hs ? 8'd0 : r_cnt + 8'd1;
      RLAST       <= ar_hs ? (ARLEN == 8'd0) : (r_cnt + 8'd1 == ar_len);
      RDATA       <= f_ok ? mem[widx(f_addr)] : '0;
      RRESP       <= f_ok ? OKAY : SLVERR;
    end else if (r_hs) begin
      RLAST <= 1'b0;
    end
endmodule
